// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory initiator and its responder.
// The byte-to-word helper is the single definition of the data-region address map.
package mem_pkg;

  localparam int unsigned MEM_WORD_COUNT = 64;
  localparam int unsigned MEM_ADDR_W     = 6;
  localparam int unsigned MEM_OFFSET     = 1024;
  localparam int unsigned MEM_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [29:0] word;
    logic        err;
  } xlate_t;

  // The two byte-select bits are dropped; below-base addresses wrap and are flagged.
  function automatic xlate_t byte_to_word(input logic [31:0] byte_addr,
                                          input logic [31:0] base,
                                          input logic [31:0] words);
    xlate_t r;
    r.word = 30'((byte_addr - base) >> 2);
    r.err  = (byte_addr < base) || ({2'b00, r.word} >= words);
    return r;
  endfunction

endpackage

// File: rtl/mem_addr_xlate.sv
// Combinational byte-address to word-index translation with range check.
// Shared by the initiator and the data-memory responder so both agree on the map.
module mem_addr_xlate
  import mem_pkg::*;
#(
  parameter int unsigned WORD_COUNT = MEM_WORD_COUNT,
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned OFFSET     = MEM_OFFSET
) (
  input  logic [31:0]       byte_addr,
  output logic [ADDR_W-1:0] word_addr,
  output logic              range_err
);

  xlate_t xl;
  logic   unused_word_hi;

  assign xl             = byte_to_word(byte_addr, 32'(OFFSET), 32'(WORD_COUNT));
  assign word_addr      = xl.word[ADDR_W-1:0];
  assign range_err      = xl.err;
  // Upper index bits only matter through the range check.
  assign unused_word_hi = ^xl.word[29:ADDR_W];

endmodule

// File: rtl/mem_access_initiator.sv
// MEM-stage initiator: one SRAM read or write per instruction over req/ready,
// freezing the pipeline until the access completes, errors out or times out.
module mem_access_initiator
  import mem_pkg::*;
#(
  parameter int unsigned WORD_COUNT = MEM_WORD_COUNT,
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned OFFSET     = MEM_OFFSET,
  parameter int unsigned TIMEOUT    = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       val_rm_in,
  input  logic              mem_read_enable_in,
  input  logic              mem_write_enable_in,
  output logic [31:0]       result_out,
  output logic              done_out,
  output logic              err_out,
  output logic              freeze_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in,
  input  logic              mem_ready_in
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              we_reg, we_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       result_reg, result_next;
  logic              err_pend_reg, err_pend_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [ADDR_W-1:0] xl_addr;
  logic              xl_err;
  logic              any_en;

  mem_addr_xlate #(
    .WORD_COUNT(WORD_COUNT),
    .ADDR_W    (ADDR_W),
    .OFFSET    (OFFSET)
  ) u_xlate (
    .byte_addr(alu_res_in),
    .word_addr(xl_addr),
    .range_err(xl_err)
  );

  assign any_en = mem_read_enable_in | mem_write_enable_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      result_reg   <= '0;
      err_pend_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      result_reg   <= result_next;
      err_pend_reg <= err_pend_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    result_next   = result_reg;
    err_pend_next = err_pend_reg;
    cnt_next      = cnt_reg;
    freeze_out    = 1'b0;
    mem_req_out   = 1'b0;
    done_out      = 1'b0;
    err_out       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (any_en) begin
          freeze_out = 1'b1;
          if (xl_err) begin
            err_pend_next = 1'b1;
            state_next    = DONE;
          end else begin
            // Write wins when both enables are set.
            addr_next     = xl_addr;
            we_next       = mem_write_enable_in;
            wdata_next    = val_rm_in;
            err_pend_next = 1'b0;
            cnt_next      = '0;
            state_next    = REQ;
          end
        end
      end

      REQ: begin
        freeze_out  = 1'b1;
        mem_req_out = 1'b1;
        if (mem_ready_in) begin
          if (!we_reg) begin
            result_next = mem_rdata_in;
          end
          err_pend_next = 1'b0;
          cnt_next      = '0;
          state_next    = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          err_pend_next = 1'b1;
          cnt_next      = '0;
          state_next    = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        // The pipeline still shows the finished instruction here, so inputs are ignored.
        done_out      = 1'b1;
        err_out       = err_pend_reg;
        err_pend_next = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign result_out    = result_reg;
  assign mem_we_out    = we_reg;
  assign mem_addr_out  = addr_reg;
  assign mem_wdata_out = wdata_reg;

endmodule

// File: doc/mem_access_initiator.md
Name: mem_access_initiator

Overview:
- Memory-stage initiator between the MEM pipeline stage and a multi-cycle, word-addressed data SRAM.
- Translates pipeline byte addresses to word indices and issues one read or write per instruction over a req/ready handshake.
- Freezes the pipeline while an access is outstanding, then returns read data and flags range or timeout errors.
- Acts as the requesting end of the data-memory interface; the SRAM is the responder.

Parameters:
- WORD_COUNT, 64, number of 32-bit words in the data memory.
- ADDR_W, 6, memory word-address width (clog2 of WORD_COUNT).
- OFFSET, 1024, byte base address of the data region.
- TIMEOUT, 16, maximum cycles spent in REQ before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alu_res_in  in  32  byte address from the EX/MEM register.
- val_rm_in  in  32  store data.
- mem_read_enable_in  in  1  load request.
- mem_write_enable_in  in  1  store request.
- result_out  out  32  load data, registered.
- done_out  out  1  one-cycle pulse when an access completes or aborts.
- err_out  out  1  one-cycle pulse, coincident with done_out, on range error or timeout.
- freeze_out  out  1  stalls the pipeline.
- mem_req_out  out  1  request to the SRAM.
- mem_we_out  out  1  1 = write, 0 = read.
- mem_addr_out  out  ADDR_W  word address.
- mem_wdata_out  out  32  write data.
- mem_rdata_in  in  32  read data, valid when mem_ready_in = 1.
- mem_ready_in  in  1  SRAM accepts a write or returns read data.

Behaviour:
- Reset (rst = 0, async): state IDLE; all outputs 0; timeout counter 0.
  - Reset during REQ drops mem_req_out immediately; the access is abandoned.
- Address calculation: byte_off = alu_res_in - OFFSET (32-bit, unsigned); word = byte_off[31:2]; byte_off[1:0] ignored.
  - Range error when alu_res_in < OFFSET or word >= WORD_COUNT.
  - mem_addr_out = word[ADDR_W-1:0].
- If both enables are asserted, the write wins and the read is suppressed.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - No enable asserted: stay in IDLE.
  - Enable asserted and address in range: latch addr, we and wdata; next state REQ.
  - Enable asserted and range error: no request issued; next state DONE with err pending.
- REQ:
  - mem_req_out = 1; addr, we and wdata held stable.
  - Counter increments each cycle.
  - mem_ready_in = 1: for a read, result_out <= mem_rdata_in; next state DONE; counter cleared.
  - Counter reaches TIMEOUT-1 with mem_ready_in = 0: drop req, err pending, next state DONE; result_out unchanged.
  - Ready and timeout in the same cycle: ready wins, no error.
- DONE (exactly one cycle):
  - done_out = 1; err_out = err pending.
  - Inputs are ignored, because the pipeline still presents the same instruction.
  - Next state IDLE.
- freeze_out (combinational) = (IDLE and any enable) or REQ. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Latency:
  - Read with ready on first REQ cycle: issue cycle, REQ, DONE = 3 cycles; freeze high for 2 cycles.
  - Write: identical timing; result_out unchanged.
- result_out holds its last load value between accesses.

Decomposition:
- Shared package (mem_pkg): state enum {IDLE, REQ, DONE}; constants WORD_COUNT, OFFSET, TIMEOUT; a function for the byte-to-word address with range check.
- One natural sub-module: mem_addr_xlate, a combinational block for offset subtract, word index and range error, reusable by the data_memory responder.

Test Plan:
- Reset mid-REQ: hold ready low, assert rst = 0 -> mem_req_out falls asynchronously; after release, state IDLE and freeze_out = 0.
- Write: alu = 1032, val = 0xDEADBEEF, wr = 1, ready on first REQ cycle -> mem_addr = 2, mem_we = 1, mem_wdata = 0xDEADBEEF; done pulse at cycle 3; freeze high for cycles 1-2.
- Read with ready after 3 wait cycles: alu = 1032, rd = 1, rdata = 0x12345678 -> result_out = 0x12345678 at done; freeze high for 5 cycles; err_out = 0.
- Range errors:
  - alu = 1020, rd = 1 -> no mem_req_out; done_out = err_out = 1 in cycle 2.
  - alu = 1024 + 256 -> same response.
- Timeout: rd = 1, ready never asserted -> req high exactly 16 cycles, then done + err, result_out unchanged; ready asserted on cycle 16 instead -> no error.
- Both enables: rd = wr = 1, alu = 1028 -> write issued (mem_we = 1, addr 1); no re-issue in DONE while inputs are still held.
